mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// - MEM pipeline stage, directly downstream of the execute stage. Consumes its result, memory flags, byte-lane select and store data.
// - Runs a valid/ready handshake to the data RAM, requests a pipeline stall while waiting, extracts and extends load data.
// - Registers the write-back bundle toward the WB stage. A bounded-wait counter aborts hung accesses.
// PARAMETERS
// - TIMEOUT_CYCLES  255  max request cycles without ram_ready before abort; 0 = never abort
// - CNT_WIDTH       8    width of the wait counter; must hold TIMEOUT_CYCLES
// PORTS
// - clk                  in   1   rising-edge clock
// - rst                  in   1   asynchronous, active-high reset
// - mem_read_flag_in     in   1   load in this slot
// - mem_write_flag_in    in   1   store in this slot
// - mem_sign_ext_flag_in in   1   sign-extend load data (else zero-extend)
// - mem_sel_in           in   4   byte-lane mask, word-relative: 0001/0010/0100/1000 byte, 0011/1100 half, 1111 word
// - mem_write_data_in    in   32  store data, right-aligned
// - result_in            in   32  EX result; memory address when read/write flag is set
// - reg_write_en_in      in   1   write-back enable (already cleared by EX for stores)
// - reg_write_addr_in    in   5   destination register
// - current_pc_addr_in   in   32  PC of this slot
// - ram_en               out  1   request valid
// - ram_write_en         out  4   per-byte write strobe
// - ram_addr             out  32  word-aligned address
// - ram_write_data       out  32  lane-replicated store data
// - ram_read_data        in   32  read word, valid with ram_ready
// - ram_ready            in   1   transfer completes at this rising edge
// - stall_req            out  1   hold upstream stages and inputs stable
// - bus_error            out  1   one-cycle pulse, access aborted by timeout
// - wb_result            out  32  registered write-back data
// - wb_reg_write_en      out  1   registered write-back enable
// - wb_reg_write_addr    out  5   registered destination
// - wb_pc_addr           out  32  registered PC
// BEHAVIOUR
// - acc = mem_read_flag_in | mem_write_flag_in.
// - Upstream holds every *_in signal stable while stall_req=1.
// - Request outputs are combinational from the inputs and gated by abort state:
//   - ram_en = acc & !abort_now
//   - ram_addr = {result_in[31:2],2'b00}
//   - ram_write_en = mem_sel_in & {4{mem_write_flag_in & ram_en}}
//   - ram_write_data: byte sel = {4{d[7:0]}}, half sel = {2{d[15:0]}}, word = d
// - Alignment is not checked; mem_sel_in is trusted as consistent with result_in[1:0].
// - FSM state IDLE (no access pending):
//   - acc & ram_ready: completes in the same cycle, stall_req=0, stay in IDLE.
//   - acc & !ram_ready: stall_req=1, cnt<=1, go to WAIT.
// - FSM state WAIT (access pending):
//   - ram_ready: completes, stall_req=0, go to IDLE.
//   - else cnt<=cnt+1, stall_req=1, stay in WAIT.
// - Abort: abort_now = WAIT & !ram_ready & TIMEOUT_CYCLES!=0 & cnt==TIMEOUT_CYCLES.
//   - In that cycle: ram_en=0, stall_req=0, WB bundle is a bubble, next state IDLE, bus_error=1 in the next cycle only.
// - Zero-wait RAM (ready in the first cycle) gives no stall, 1-cycle latency to WB.
// - N wait cycles give N stall cycles.
// - Load extract: the lowest set bit of mem_sel_in selects lane k. Byte = rd[8k+7:8k]; half = rd[8k+15:8k].
//   - Extend with sign (mem_sign_ext_flag_in=1) or zeros. Word = rd unchanged.
// - WB register updates every edge:
//   - stall_req=1 or abort cycle: wb_reg_write_en<=0, other wb_* hold.
//   - else: wb_result<= load ? extracted : result_in; other wb_* <= inputs.
// - Stores never write back, even if reg_write_en_in is set.
// - Reset: all outputs 0, state IDLE, cnt 0. Reset while in WAIT drops ram_en at once; the pending transfer is discarded.
// - ram_ready asserted with acc=0 is ignored.
// TESTING
// - ALU op result_in=0x12345678, reg 5, ready don't-care -> ram_en=0, no stall; next cycle wb_result=0x12345678, wb_reg_write_en=1, wb_reg_write_addr=5.
// - Signed byte load, sel 0100, rd=0x00800000, ready in the same cycle -> no stall; wb_result=0xFFFFFF80. Repeat unsigned -> 0x00000080.
// - Half store sel 1100, d=0xBEEF, addr 0x1002, ready after 3 cycles -> ram_addr=0x1000, strobe 1100, data 0xBEEFBEEF; stall_req=1 for 3 cycles; wb_reg_write_en=0 throughout.
// - Word load, ready held low, TIMEOUT_CYCLES=4 -> stall for 4 cycles, ram_en low in the abort cycle, one-cycle bus_error pulse, WB bubble, next slot accepted.
// - rst asserted during WAIT -> ram_en, stall_req and all wb_* drop to 0 immediately; after release the first ALU op completes normally.
// - Back-to-back zero-wait load then store -> two consecutive completions, stall_req never asserted.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-RAM handshake, stalls upstream while a transfer is pending,
// extracts/extends load data and registers the write-back bundle; a wait counter aborts hung accesses.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic        stall_req,
  output logic        bus_error,
  output logic [31:0] wb_result,
  output logic        wb_reg_write_en,
  output logic [4:0]  wb_reg_write_addr,
  output logic [31:0] wb_pc_addr
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                   TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  bus_error_q;
  logic [31:0]           wb_result_q, wb_result_d;
  logic                  wb_we_q, wb_we_d;
  logic [4:0]            wb_addr_q, wb_addr_d;
  logic [31:0]           wb_pc_q, wb_pc_d;

  logic        acc;
  logic        abort_now;
  logic        stall;
  logic        sel_word;
  logic        sel_half;
  logic [1:0]  lane;
  logic [31:0] lane_data;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign acc = mem_read_flag_in | mem_write_flag_in;

  assign abort_now = (state_q == ST_WAIT) & ~ram_ready & TIMEOUT_EN & (cnt_q == TIMEOUT_CNT);

  // Upstream holds acc high throughout WAIT, so one expression covers both states.
  assign stall = acc & ~ram_ready & ~abort_now;

  assign stall_req      = ~rst & stall;
  assign ram_en         = ~rst & acc & ~abort_now;
  assign ram_addr       = rst ? 32'h0 : {result_in[31:2], 2'b00};
  assign ram_write_en   = mem_sel_in & {4{mem_write_flag_in & ram_en}};
  assign ram_write_data = rst ? 32'h0 : store_data;

  assign sel_word = (mem_sel_in == 4'b1111);
  assign sel_half = (mem_sel_in == 4'b0011) | (mem_sel_in == 4'b1100);

  always_comb begin
    store_data = mem_write_data_in;
    if (sel_half) begin
      store_data = {2{mem_write_data_in[15:0]}};
    end else if (!sel_word) begin
      store_data = {4{mem_write_data_in[7:0]}};
    end
  end

  // Lowest set bit of the lane mask picks the starting byte lane.
  always_comb begin
    lane = 2'd0;
    if (mem_sel_in[0]) begin
      lane = 2'd0;
    end else if (mem_sel_in[1]) begin
      lane = 2'd1;
    end else if (mem_sel_in[2]) begin
      lane = 2'd2;
    end else if (mem_sel_in[3]) begin
      lane = 2'd3;
    end
  end

  assign lane_data = ram_read_data >> {lane, 3'b000};

  always_comb begin
    load_data = ram_read_data;
    if (sel_half) begin
      load_data = {{16{mem_sign_ext_flag_in & lane_data[15]}}, lane_data[15:0]};
    end else if (!sel_word) begin
      load_data = {{24{mem_sign_ext_flag_in & lane_data[7]}}, lane_data[7:0]};
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    if (!abort_now && stall) begin
      state_d = ST_WAIT;
      if (state_q == ST_IDLE) begin
        cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (&cnt_q) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stall and abort cycles insert a bubble; payload fields keep their last value.
  always_comb begin
    wb_result_d = wb_result_q;
    wb_we_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_pc_d     = wb_pc_q;
    if (!stall && !abort_now) begin
      wb_result_d = mem_read_flag_in ? load_data : result_in;
      wb_we_d     = reg_write_en_in & ~mem_write_flag_in;
      wb_addr_d   = reg_write_addr_in;
      wb_pc_d     = current_pc_addr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
      wb_result_q <= 32'h0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= 5'h0;
      wb_pc_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= abort_now;
      wb_result_q <= wb_result_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_pc_q     <= wb_pc_d;
    end
  end

  assign bus_error         = bus_error_q;
  assign wb_result         = wb_result_q;
  assign wb_reg_write_en   = wb_we_q;
  assign wb_reg_write_addr = wb_addr_q;
  assign wb_pc_addr        = wb_pc_q;

endmodule
